// File: rtl/tong_led_pkg.sv
// rtl/tong_led_pkg.sv - shared state type and LED constants for the tong_led fade/fill sequencer
package tong_led_pkg;

    localparam int        LED_W       = 8;
    localparam logic [7:0] LED_ALL_ON  = 8'hFF;
    localparam logic [7:0] LED_ALL_OFF = 8'h00;

    typedef enum logic [1:0] {
        FADE     = 2'd0,
        FILL     = 2'd1,
        HOLD_OFF = 2'd2,
        HOLD_ON  = 2'd3
    } tong_led_state_t;

endpackage

// File: rtl/tong_led_tick.sv
// rtl/tong_led_tick.sv - step prescaler, one-cycle tick every STEP_CYCLES clocks
module tong_led_tick #(
    parameter int STEP_CYCLES = 25_000_000
) (
    input  logic CLK,
    input  logic rs,
    output logic tick
);

    // A single-cycle step still needs a one-bit counter that simply sits at zero.
    localparam int               CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Terminal count raises tick and wraps the counter on the same edge.
    always_comb begin
        tick  = (cnt_q == CNT_LAST);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    // Counter register; reset restarts the step phase.
    always_ff @(posedge CLK) begin
        if (!rs) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tong_led.sv
// rtl/tong_led.sv - 8-LED fade-out/fill-in shift sequencer; optional end holds via TONG_LED_HOLD_EN
module tong_led
    import tong_led_pkg::*;
#(
    parameter int STEP_CYCLES = 25_000_000,
    parameter int HOLD_STEPS  = 4
) (
    input  logic             CLK,
    input  logic             rs,
    output logic [LED_W-1:0] led
);

    // Reject nonsensical step/hold settings at elaboration.
    if (STEP_CYCLES < 1 || HOLD_STEPS < 1) begin : g_bad_param
        $error("tong_led: STEP_CYCLES and HOLD_STEPS must both be >= 1");
    end

    logic tick;

    tong_led_tick #(
        .STEP_CYCLES(STEP_CYCLES)
    ) u_tick (
        .CLK (CLK),
        .rs  (rs),
        .tick(tick)
    );

    tong_led_state_t  state_q;
    tong_led_state_t  state_d;
    logic [LED_W-1:0] led_q;
    logic [LED_W-1:0] led_d;

`ifdef TONG_LED_HOLD_EN
    localparam int               HOLD_W    = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);

    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_d;
`endif

    // Next-state: shift one LED per tick, turn around at all-off / all-on.
    always_comb begin
        state_d = state_q;
        led_d   = led_q;
`ifdef TONG_LED_HOLD_EN
        hold_d  = hold_q;
`endif
        if (tick) begin
            case (state_q)
                FADE: begin
                    led_d = {1'b0, led_q[LED_W-1:1]};
                    if (led_d == LED_ALL_OFF) begin
`ifdef TONG_LED_HOLD_EN
                        state_d = HOLD_OFF;
                        hold_d  = '0;
`else
                        state_d = FILL;
`endif
                    end
                end
                FILL: begin
                    led_d = {led_q[LED_W-2:0], 1'b1};
                    if (led_d == LED_ALL_ON) begin
`ifdef TONG_LED_HOLD_EN
                        state_d = HOLD_ON;
                        hold_d  = '0;
`else
                        state_d = FADE;
`endif
                    end
                end
`ifdef TONG_LED_HOLD_EN
                HOLD_OFF: begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = FILL;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                HOLD_ON: begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = FADE;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
`endif
                default: begin
                    // Unreachable encodings recover to the reset pattern.
                    state_d = FADE;
                    led_d   = LED_ALL_ON;
                end
            endcase
        end
    end

    // State and LED registers; reset takes priority over a coincident tick.
    always_ff @(posedge CLK) begin
        if (!rs) begin
            state_q <= FADE;
            led_q   <= LED_ALL_ON;
`ifdef TONG_LED_HOLD_EN
            hold_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            led_q   <= led_d;
`ifdef TONG_LED_HOLD_EN
            hold_q  <= hold_d;
`endif
        end
    end

    assign led = led_q;

endmodule

// File: tb/tb_tong_led.sv
// tb/tb_tong_led.sv - directed self-checking bench for tong_led (with and without TONG_LED_HOLD_EN)
module tb_tong_led;
    import tong_led_pkg::*;

    logic       CLK = 1'b0;
    logic       rs1 = 1'b0;
    logic       rs5 = 1'b0;
    logic [7:0] led1;
    logic [7:0] led5;

    int n_cmp = 0;
    int n_bad = 0;

    always #10 CLK = ~CLK;

    tong_led #(.STEP_CYCLES(1), .HOLD_STEPS(2)) dut1 (
        .CLK(CLK),
        .rs (rs1),
        .led(led1)
    );

    tong_led #(.STEP_CYCLES(5), .HOLD_STEPS(2)) dut5 (
        .CLK(CLK),
        .rs (rs5),
        .led(led5)
    );

`ifdef TONG_LED_HOLD_EN
    localparam int PERIOD = 20;
    logic [7:0] seq [PERIOD] = '{8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00,
                                 8'h00, 8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F,
                                 8'h7F, 8'hFF, 8'hFF, 8'hFF};
`else
    localparam int PERIOD = 16;
    logic [7:0] seq [PERIOD] = '{8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00,
                                 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
`endif

    task automatic test_reset();
        rs1 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            n_cmp++;
            if (led1 !== 8'hFF) begin
                n_bad++;
                $display("FAIL reset_hold[%0d]: led=%h expected=%h", i, led1, 8'hFF);
            end
        end
        rs1 = 1'b1;
        @(negedge CLK);
        n_cmp++;
        if (led1 !== 8'h7F) begin
            n_bad++;
            $display("FAIL reset_first_step: led=%h expected=%h", led1, 8'h7F);
        end
    endtask

    task automatic test_full_cycle();
        rs1 = 1'b0;
        @(negedge CLK);
        rs1 = 1'b1;
        for (int k = 1; k <= 2 * PERIOD + 2; k++) begin
            @(negedge CLK);
            n_cmp++;
            if (led1 !== seq[(k - 1) % PERIOD]) begin
                n_bad++;
                $display("FAIL full_cycle[edge %0d]: led=%h expected=%h", k, led1, seq[(k - 1) % PERIOD]);
            end
        end
    endtask

    task automatic test_prescaler();
        logic [7:0] exp;
        rs5 = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        rs5 = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge CLK);
            exp = (k < 5) ? 8'hFF : (k < 10) ? 8'h7F : 8'h3F;
            n_cmp++;
            if (led5 !== exp) begin
                n_bad++;
                $display("FAIL prescaler[edge %0d]: led=%h expected=%h", k, led5, exp);
            end
        end
    endtask

    task automatic test_mid_reset();
        bit found = 0;
        rs1 = 1'b0;
        @(negedge CLK);
        rs1 = 1'b1;
        // Skip past the fade half so the 07 we catch is on the fill side.
        for (int k = 1; k <= 9; k++) @(negedge CLK);
        for (int k = 0; k < 40 && !found; k++) begin
            if (led1 === 8'h07) found = 1;
            else @(negedge CLK);
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL mid_reset_find_07: led=%h expected=%h within budget", led1, 8'h07);
        end
        rs1 = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if (led1 !== 8'hFF) begin
            n_bad++;
            $display("FAIL mid_reset_ff: led=%h expected=%h", led1, 8'hFF);
        end
        rs1 = 1'b1;
        @(negedge CLK);
        n_cmp++;
        if (led1 !== 8'h7F) begin
            n_bad++;
            $display("FAIL mid_reset_resume1: led=%h expected=%h", led1, 8'h7F);
        end
        @(negedge CLK);
        n_cmp++;
        if (led1 !== 8'h3F) begin
            n_bad++;
            $display("FAIL mid_reset_resume2: led=%h expected=%h", led1, 8'h3F);
        end
    endtask

    task automatic test_reset_over_tick();
        // dut5 held in reset across several would-be ticks must not move.
        rs5 = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(negedge CLK);
            n_cmp++;
            if (led5 !== 8'hFF) begin
                n_bad++;
                $display("FAIL reset_over_tick[%0d]: led=%h expected=%h", k, led5, 8'hFF);
            end
        end
        rs5 = 1'b1;
    endtask

    initial begin
        @(negedge CLK);
        test_reset();
        test_full_cycle();
        test_prescaler();
        test_mid_reset();
        test_reset_over_tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
